// File: rtl/logic_gate_bank_bist.sv
// Bank of WIDTH two-input gate lanes with a registered result
// and a built-in self-test that sweeps all modes and patterns.
module logic_gate_bank_bist #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             CLR_N,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       MODE,
   input  logic             LD,
   input  logic             FAULT,
   input  logic             BIST_START,
   output logic [WIDTH-1:0] Y,
   output logic             BIST_BUSY,
   output logic             BIST_DONE,
   output logic             BIST_PASS
);

   typedef enum logic [1:0] {
      IDLE,
      APPLY,
      CHECK,
      DONE
   } state_t;

   // Golden results indexed by {mode, pattern}, kept apart from gate_f
   localparam logic [15:0] EXP_TBL = 16'h6187;

   state_t           state_q;
   state_t           state_d;
   logic [3:0]       idx_q;
   logic             err_q;
   logic             pass_q;
   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] pat_a;
   logic [WIDTH-1:0] pat_b;
   logic [WIDTH-1:0] exp_vec;
   logic             ld_fire;
   logic             bist_go;

   function automatic logic [WIDTH-1:0] gate_f(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic [1:0]       m,
      input logic             flt
   );
      logic [WIDTH-1:0] r;
      unique case (m)
         2'b00:   r = a | b;
         2'b01:   r = ~(a | b);
         2'b10:   r = a & b;
         default: r = a ^ b;
      endcase
      r[0] = r[0] ^ flt;
      return r;
   endfunction

   assign pat_a   = {WIDTH{~idx_q[1]}};
   assign pat_b   = {WIDTH{~idx_q[0]}};
   assign exp_vec = {WIDTH{EXP_TBL[idx_q]}};

   always_comb begin
      state_d = state_q;
      ld_fire = 1'b0;
      bist_go = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (BIST_START) begin
               state_d = APPLY;
               bist_go = 1'b1;
            end else if (LD) begin
               ld_fire = 1'b1;
            end
         end
         APPLY:   state_d = CHECK;
         CHECK:   state_d = (idx_q == 4'd15) ? DONE : APPLY;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state_q <= IDLE;
         idx_q   <= '0;
         err_q   <= 1'b0;
         pass_q  <= 1'b0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         if (bist_go) begin
            idx_q  <= '0;
            err_q  <= 1'b0;
            pass_q <= 1'b0;
         end
         if (ld_fire)
            y_q <= gate_f(A, B, MODE, FAULT);
         if (state_q == APPLY)
            y_q <= gate_f(pat_a, pat_b, idx_q[3:2], FAULT);
         if (state_q == CHECK) begin
            if (y_q != exp_vec)
               err_q <= 1'b1;
            if (idx_q != 4'd15)
               idx_q <= idx_q + 4'd1;
         end
         if (state_q == DONE)
            pass_q <= ~err_q;
      end
   end

   assign Y         = y_q;
   assign BIST_BUSY = (state_q != IDLE);
   assign BIST_DONE = (state_q == DONE);
   assign BIST_PASS = pass_q;

endmodule

// File: tb/tb_logic_gate_bank_bist.sv
// Directed-vector bench for logic_gate_bank_bist (WIDTH 4 and 8).
module tb_logic_gate_bank_bist;

   logic       CLK = 1'b0;
   logic       CLR_N = 1'b0;
   logic [3:0] A = '0;
   logic [3:0] B = '0;
   logic [1:0] MODE = '0;
   logic       LD = 1'b0;
   logic       FAULT = 1'b0;
   logic       BIST_START = 1'b0;
   logic [3:0] Y;
   logic       BIST_BUSY;
   logic       BIST_DONE;
   logic       BIST_PASS;

   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       ld8 = 1'b0;
   logic [7:0] y8;
   logic       busy8;
   logic       done8;
   logic       pass8;

   int total = 0;
   int passed = 0;

   logic [15:0] exp_tbl = 16'h6187;

   always #5 CLK = ~CLK;

   logic_gate_bank_bist #(.WIDTH(4)) dut (
      .CLK(CLK), .CLR_N(CLR_N), .A(A), .B(B), .MODE(MODE),
      .LD(LD), .FAULT(FAULT), .BIST_START(BIST_START),
      .Y(Y), .BIST_BUSY(BIST_BUSY), .BIST_DONE(BIST_DONE),
      .BIST_PASS(BIST_PASS)
   );

   logic_gate_bank_bist #(.WIDTH(8)) dut8 (
      .CLK(CLK), .CLR_N(CLR_N), .A(a8), .B(b8), .MODE(MODE),
      .LD(ld8), .FAULT(1'b0), .BIST_START(1'b0),
      .Y(y8), .BIST_BUSY(busy8), .BIST_DONE(done8),
      .BIST_PASS(pass8)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic run_bist(
      input  logic poke,
      output int   busy_n,
      output int   done_n,
      output int   done_k,
      output int   ymis,
      output logic pass_early
   );
      logic [3:0] e;
      int k;
      busy_n = 0; done_n = 0; done_k = -1; ymis = 0;
      pass_early = 1'bx;
      BIST_START = 1'b1;
      tick();
      BIST_START = 1'b0;
      k = 1;
      while (BIST_BUSY && k <= 60) begin
         busy_n++;
         if (BIST_DONE) begin
            done_n++;
            done_k = k;
         end
         if (k == 1) pass_early = BIST_PASS;
         if (k >= 2 && k <= 33) begin
            e = {4{exp_tbl[(k/2)-1]}} ^ {3'b000, FAULT};
            if (Y !== e) ymis++;
         end
         LD = poke && (k == 5 || k == 12 || k == 20);
         BIST_START = LD;
         if (poke) begin
            A = 4'h0; B = 4'h0; MODE = 2'b01;
         end
         tick();
         k++;
      end
      LD = 1'b0;
      BIST_START = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      total++; if (Y !== 4'h0) $display("FAIL rst_y Y=%h exp=0", Y); else passed++;
      total++; if (BIST_BUSY !== 1'b0) $display("FAIL rst_busy got=%b exp=0", BIST_BUSY); else passed++;
      total++; if (BIST_DONE !== 1'b0) $display("FAIL rst_done got=%b exp=0", BIST_DONE); else passed++;
      total++; if (BIST_PASS !== 1'b0) $display("FAIL rst_pass got=%b exp=0", BIST_PASS); else passed++;
      @(negedge CLK);
      CLR_N = 1'b1;
   endtask

   task automatic test_or_lanes();
      logic [3:0] va [4] = '{4'hF, 4'hF, 4'h0, 4'h0};
      logic [3:0] vb [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
      logic [3:0] ve [4] = '{4'hF, 4'hF, 4'hF, 4'h0};
      MODE = 2'b00;
      for (int i = 0; i < 4; i++) begin
         A = va[i]; B = vb[i]; LD = 1'b1;
         tick();
         total++;
         if (Y !== ve[i]) $display("FAIL or_p%0d Y=%h exp=%h", i, Y, ve[i]);
         else passed++;
      end
      LD = 1'b0; A = 4'hF; B = 4'hF;
      tick();
      total++; if (Y !== 4'h0) $display("FAIL hold Y=%h exp=0", Y); else passed++;
   endtask

   task automatic test_width8();
      MODE = 2'b11; a8 = 8'hF0; b8 = 8'hFF; ld8 = 1'b1;
      tick();
      total++; if (y8 !== 8'h0F) $display("FAIL w8_xor Y=%h exp=0f", y8); else passed++;
      MODE = 2'b10; a8 = 8'hAA; b8 = 8'h0F;
      tick();
      total++; if (y8 !== 8'h0A) $display("FAIL w8_and Y=%h exp=0a", y8); else passed++;
      ld8 = 1'b0;
   endtask

   task automatic test_bist_pass();
      int bn, dn, dk, ym;
      logic pe;
      FAULT = 1'b0;
      run_bist(1'b0, bn, dn, dk, ym, pe);
      total++; if (bn != 33) $display("FAIL bp_busy cycles=%0d exp=33", bn); else passed++;
      total++; if (dn != 1) $display("FAIL bp_done pulses=%0d exp=1", dn); else passed++;
      total++; if (dk != 33) $display("FAIL bp_done_at cycle=%0d exp=33", dk); else passed++;
      total++; if (ym != 0) $display("FAIL bp_yseq mism=%0d exp=0", ym); else passed++;
      total++; if (BIST_PASS !== 1'b1) $display("FAIL bp_pass got=%b exp=1", BIST_PASS); else passed++;
      total++; if (Y !== 4'h0) $display("FAIL bp_y Y=%h exp=0", Y); else passed++;
   endtask

   task automatic test_bist_fault();
      int bn, dn, dk, ym;
      logic pe;
      FAULT = 1'b1;
      run_bist(1'b0, bn, dn, dk, ym, pe);
      total++; if (pe !== 1'b0) $display("FAIL bf_clr pass=%b exp=0", pe); else passed++;
      total++; if (bn != 33) $display("FAIL bf_busy cycles=%0d exp=33", bn); else passed++;
      total++; if (dk != 33 || dn != 1) $display("FAIL bf_done at=%0d n=%0d exp=33/1", dk, dn); else passed++;
      total++; if (ym != 0) $display("FAIL bf_yseq mism=%0d exp=0", ym); else passed++;
      total++; if (BIST_PASS !== 1'b0) $display("FAIL bf_pass got=%b exp=0", BIST_PASS); else passed++;
      total++; if (Y !== 4'h1) $display("FAIL bf_y Y=%h exp=1", Y); else passed++;
      FAULT = 1'b0;
      run_bist(1'b0, bn, dn, dk, ym, pe);
      total++; if (BIST_PASS !== 1'b1) $display("FAIL bf_rerun pass=%b exp=1", BIST_PASS); else passed++;
      repeat (3) tick();
      total++; if (BIST_PASS !== 1'b1) $display("FAIL bf_sticky pass=%b exp=1", BIST_PASS); else passed++;
   endtask

   task automatic test_reset_mid();
      logic seen;
      BIST_START = 1'b1;
      tick();
      BIST_START = 1'b0;
      repeat (9) tick();
      total++; if (BIST_BUSY !== 1'b1) $display("FAIL rm_busy got=%b exp=1", BIST_BUSY); else passed++;
      #2 CLR_N = 1'b0;
      #1;
      total++;
      if ({Y, BIST_BUSY, BIST_DONE, BIST_PASS} !== 7'b0)
         $display("FAIL rm_async Y=%h b=%b d=%b p=%b exp=all0", Y, BIST_BUSY, BIST_DONE, BIST_PASS);
      else passed++;
      seen = 1'b0;
      repeat (3) begin
         tick();
         if (BIST_DONE !== 1'b0) seen = 1'b1;
      end
      total++; if (seen) $display("FAIL rm_nodone got=1 exp=0"); else passed++;
      @(negedge CLK);
      CLR_N = 1'b1;
      MODE = 2'b01; A = 4'h0; B = 4'h0; LD = 1'b1;
      tick();
      LD = 1'b0;
      total++; if (Y !== 4'hF) $display("FAIL rm_ld Y=%h exp=f", Y); else passed++;
      total++; if (BIST_BUSY !== 1'b0) $display("FAIL rm_idle busy=%b exp=0", BIST_BUSY); else passed++;
   endtask

   task automatic test_back_to_back();
      int bn, dn, dk, ym;
      logic pe;
      FAULT = 1'b0;
      run_bist(1'b1, bn, dn, dk, ym, pe);
      total++; if (bn != 33) $display("FAIL bb_busy cycles=%0d exp=33", bn); else passed++;
      total++; if (dn != 1 || dk != 33) $display("FAIL bb_done n=%0d at=%0d exp=1/33", dn, dk); else passed++;
      total++; if (ym != 0) $display("FAIL bb_yseq mism=%0d exp=0", ym); else passed++;
      total++; if (BIST_PASS !== 1'b1) $display("FAIL bb_pass got=%b exp=1", BIST_PASS); else passed++;
      tick();
      total++; if (BIST_BUSY !== 1'b0 || Y !== 4'h0) $display("FAIL bb_end busy=%b Y=%h exp=0/0", BIST_BUSY, Y); else passed++;
   endtask

   initial begin
      test_reset();
      test_or_lanes();
      test_width8();
      test_bist_pass();
      test_bist_fault();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
